// File: rtl/spi_uart_pkg.sv
// spi_uart_pkg: shared states, command words and response bit positions for the SPI UART bridge
package spi_uart_pkg;
  typedef enum logic [1:0] {INIT, IDLE, XFER, DONE} state_t;
  localparam logic [1:0] CMD_CONFIG_HI = 2'b11;
  localparam logic [1:0] CMD_WRITE_HI = 2'b10;
  localparam logic [15:0] CMD_READ = 16'h0000;
  localparam int R_BIT = 15;
  localparam int T_BIT = 14;
endpackage

// File: rtl/spi_uart_bridge_shift16.sv
// spi_shift16: SCLK divider and 16-bit full-duplex mode-0 shifter, NCS low for 36 half-periods plus a 2 half-period gap before done
module spi_shift16 #(
  parameter int SCLK_DIV = 4
) (
  input  logic        MCLK_IN,
  input  logic        RESET_IN,
  input  logic        start,
  input  logic [15:0] tx_word,
  input  logic        miso,
  output logic        done,
  output logic [15:0] rx_word,
  output logic        sclk,
  output logic        mosi,
  output logic        ncs
);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  logic          active;
  logic [DW-1:0] dc;
  logic [5:0]    hc;
  logic [5:0]    nh;
  logic [15:0]   tx_sh;
  assign nh = hc + 6'd1;
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      active  <= 1'b0;
      dc      <= '0;
      hc      <= '0;
      tx_sh   <= '0;
      rx_word <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ncs     <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active <= 1'b1;
          dc     <= '0;
          hc     <= '0;
          ncs    <= 1'b0;
          mosi   <= tx_word[15];
          tx_sh  <= {tx_word[14:0], 1'b0};
        end
      end else if (dc != DW'(SCLK_DIV - 1)) begin
        dc <= dc + 1'b1;
      end else begin
        dc <= '0;
        hc <= nh;
        if (nh < 6'd32 && nh[0]) begin
          sclk    <= 1'b1;
          rx_word <= {rx_word[14:0], miso};
        end
        if (nh <= 6'd32 && !nh[0]) begin
          sclk  <= 1'b0;
          mosi  <= tx_sh[15];
          tx_sh <= {tx_sh[14:0], 1'b0};
        end
        if (nh == 6'd36) ncs <= 1'b1;
        if (nh == 6'd38) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/spi_uart_bridge.sv
// spi_uart_bridge: turns bus-controller UART strobes into CONFIG/WRITE/READ SPI frames and returns busy/received status
module spi_uart_bridge
  import spi_uart_pkg::*;
#(
  parameter int          SCLK_DIV      = 4,
  parameter int          POLL_INTERVAL = 1024,
  parameter logic [15:0] CONFIG_WORD   = 16'hC00A
) (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic       UART_SEND_TRIGGER_IN,
  input  logic [7:0] UART_SEND_BYTE_IN,
  input  logic       UART_RECEIVE_CAPTURE_IN,
  output logic       UART_SEND_BUSY,
  output logic       UART_RECEIVED,
  output logic [7:0] UART_RECEIVE_BYTE,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO_IN,
  output logic       SPI_NCS
);
  localparam int PW = $clog2(POLL_INTERVAL) + 1;
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_INTERVAL - 1);
  state_t        state, next;
  logic          start, done;
  logic [15:0]   word, cur_word, rx_word;
  logic          tx_empty, tx_empty_d, pending, pending_d, recv_d, busy_d;
  logic [7:0]    send_byte, byte_d, rxb_d;
  logic [PW-1:0] poll, poll_d;
  logic          trig_q, cap_q;
  logic          unused_rx;
  assign unused_rx = ^rx_word[13:8];
  spi_shift16 #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .MCLK_IN (MCLK_IN),
    .RESET_IN(RESET_IN),
    .start   (start),
    .tx_word (word),
    .miso    (SPI_MISO_IN),
    .done    (done),
    .rx_word (rx_word),
    .sclk    (SPI_SCLK),
    .mosi    (SPI_MOSI),
    .ncs     (SPI_NCS)
  );
  always_comb begin
    next       = state;
    start      = 1'b0;
    word       = CMD_READ;
    pending_d  = pending;
    tx_empty_d = tx_empty;
    recv_d     = UART_RECEIVED;
    rxb_d      = UART_RECEIVE_BYTE;
    poll_d     = poll;
    byte_d     = send_byte;
    if (cap_q && !UART_RECEIVE_CAPTURE_IN) recv_d = 1'b0;
    if (UART_SEND_TRIGGER_IN && !trig_q && !UART_SEND_BUSY) begin
      pending_d = 1'b1;
      byte_d    = UART_SEND_BYTE_IN;
    end
    case (state)
      INIT: begin
        start = 1'b1;
        word  = {CMD_CONFIG_HI, CONFIG_WORD[13:0]};
        next  = XFER;
      end
      IDLE: begin
        if (pending && tx_empty) begin
          start = 1'b1;
          word  = {CMD_WRITE_HI, 6'b0, send_byte};
          next  = XFER;
        end else if (poll >= POLL_MAX && (!UART_RECEIVED || (pending && !tx_empty))) begin
          start = 1'b1;
          next  = XFER;
        end else begin
          poll_d = poll + PW'(poll != POLL_MAX);
        end
      end
      XFER: next = done ? DONE : XFER;
      default: begin
        next       = IDLE;
        poll_d     = '0;
        tx_empty_d = rx_word[T_BIT];
        if (cur_word[15:14] == CMD_WRITE_HI) begin
          pending_d  = 1'b0;
          tx_empty_d = 1'b0;
        end
        if (cur_word == CMD_READ && rx_word[R_BIT] && !recv_d) begin
          recv_d = 1'b1;
          rxb_d  = rx_word[7:0];
        end
      end
    endcase
    busy_d = pending_d | ~tx_empty_d | (next == INIT);
  end
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state             <= INIT;
      cur_word          <= '0;
      tx_empty          <= 1'b0;
      pending           <= 1'b0;
      send_byte         <= '0;
      poll              <= '0;
      trig_q            <= 1'b0;
      cap_q             <= 1'b0;
      UART_RECEIVED     <= 1'b0;
      UART_RECEIVE_BYTE <= '0;
      UART_SEND_BUSY    <= 1'b1;
    end else begin
      state             <= next;
      cur_word          <= start ? word : cur_word;
      tx_empty          <= tx_empty_d;
      pending           <= pending_d;
      send_byte         <= byte_d;
      poll              <= poll_d;
      trig_q            <= UART_SEND_TRIGGER_IN;
      cap_q             <= UART_RECEIVE_CAPTURE_IN;
      UART_RECEIVED     <= recv_d;
      UART_RECEIVE_BYTE <= rxb_d;
      UART_SEND_BUSY    <= busy_d;
    end
  end
endmodule

// File: tb/tb_spi_uart_bridge.sv
// tb_spi_uart_bridge: directed bench with an SPI UART device model driving MISO and collecting MOSI frames
module tb_spi_uart_bridge;
  logic        MCLK_IN = 1'b0;
  logic        RESET_IN = 1'b1;
  logic        trig = 1'b0;
  logic [7:0]  sbyte = 8'h00;
  logic        cap = 1'b0;
  logic        miso = 1'b0;
  logic        busy, received, sclk, mosi, ncs;
  logic [7:0]  rbyte;
  int          checks = 0;
  int          fails = 0;
  logic        ncs_p = 1'b1;
  logic        sclk_p = 1'b0;
  logic [15:0] resp = 16'h4000;
  logic [15:0] sh = 16'h0;
  logic [15:0] mw = 16'h0;
  logic [15:0] last_w = 16'h0;
  int          frames = 0;
  int          nbits = 0;
  int          low = 0;
  int          last_low = 0;
  logic [15:0] log_q[$];

  spi_uart_bridge #(.SCLK_DIV(4), .POLL_INTERVAL(16), .CONFIG_WORD(16'hC00A)) dut (
    .MCLK_IN                (MCLK_IN),
    .RESET_IN               (RESET_IN),
    .UART_SEND_TRIGGER_IN   (trig),
    .UART_SEND_BYTE_IN      (sbyte),
    .UART_RECEIVE_CAPTURE_IN(cap),
    .UART_SEND_BUSY         (busy),
    .UART_RECEIVED          (received),
    .UART_RECEIVE_BYTE      (rbyte),
    .SPI_SCLK               (sclk),
    .SPI_MOSI               (mosi),
    .SPI_MISO_IN            (miso),
    .SPI_NCS                (ncs)
  );

  always #5 MCLK_IN = ~MCLK_IN;

  always @(negedge MCLK_IN) begin
    if (!ncs) low++;
    if (ncs_p && !ncs) begin
      sh = resp;
      miso = resp[15];
      mw = 16'h0;
      nbits = 0;
    end else if (!ncs && sclk_p && !sclk) begin
      sh = {sh[14:0], 1'b0};
      miso = sh[15];
    end
    if (!ncs && !sclk_p && sclk) begin
      mw = {mw[14:0], mosi};
      nbits++;
    end
    if (!ncs_p && ncs) begin
      last_w = mw;
      last_low = low;
      frames++;
      log_q.push_back(mw);
    end
    if (ncs) low = 0;
    ncs_p = ncs;
    sclk_p = sclk;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge MCLK_IN);
  endtask

  task automatic wait_frame(output logic [15:0] w, output bit ok);
    int f0;
    int n;
    f0 = frames;
    n = 0;
    while (frames == f0 && n < 3000) begin
      @(negedge MCLK_IN);
      n++;
    end
    ok = (frames != f0);
    w = last_w;
  endtask

  task automatic wait_ncs_low(output bit ok);
    int n;
    n = 0;
    while (ncs && n < 3000) begin
      @(negedge MCLK_IN);
      n++;
    end
    ok = !ncs;
  endtask

  task automatic test_reset;
    logic [15:0] w;
    bit ok;
    RESET_IN = 1'b1;
    idle(3);
    checks++; if (ncs !== 1'b1) begin fails++; $display("FAIL reset_ncs: got %b expected 1", ncs); end
    checks++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (received !== 1'b0) begin fails++; $display("FAIL reset_received: got %b expected 0", received); end
    checks++; if (rbyte !== 8'h00) begin fails++; $display("FAIL reset_rbyte: got %h expected 00", rbyte); end
    RESET_IN = 1'b0;
    idle(1);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL init_busy: got %b expected 1", busy); end
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'hC00A) begin fails++; $display("FAIL config_frame: got %h (ok=%0d) expected c00a", w, ok); end
    idle(12);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL config_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write;
    logic [15:0] w;
    bit ok;
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL idle_poll: got %h (ok=%0d) expected 0000", w, ok); end
    idle(12);
    resp = 16'h0000;
    sbyte = 8'h41;
    trig = 1'b1;
    idle(1);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy_set: got %b expected 1", busy); end
    trig = 1'b0;
    wait_frame(w, ok);
    resp = 16'h4000;
    checks++; if (!ok || w !== 16'h8041) begin fails++; $display("FAIL write_frame: got %h (ok=%0d) expected 8041", w, ok); end
    checks++; if (last_low != 144) begin fails++; $display("FAIL write_ncs_low: got %0d expected 144", last_low); end
    idle(12);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy_hold: got %b expected 1", busy); end
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL write_followup_read: got %h (ok=%0d) expected 0000", w, ok); end
    idle(12);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_clear: got %b expected 0", busy); end
  endtask

  task automatic test_receive;
    logic [15:0] w;
    bit ok;
    int f0;
    resp = 16'hC05A;
    wait_frame(w, ok);
    resp = 16'h4000;
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL rx_read_frame: got %h (ok=%0d) expected 0000", w, ok); end
    idle(12);
    checks++; if (received !== 1'b1) begin fails++; $display("FAIL rx_received: got %b expected 1", received); end
    checks++; if (rbyte !== 8'h5A) begin fails++; $display("FAIL rx_byte: got %h expected 5a", rbyte); end
    f0 = frames;
    idle(200);
    checks++; if (frames != f0) begin fails++; $display("FAIL rx_poll_suppressed: got %0d frames expected 0", frames - f0); end
    cap = 1'b1;
    idle(3);
    checks++; if (received !== 1'b1) begin fails++; $display("FAIL rx_capture_high: got %b expected 1", received); end
    cap = 1'b0;
    idle(1);
    checks++; if (received !== 1'b0) begin fails++; $display("FAIL rx_capture_fall: got %b expected 0", received); end
    checks++; if (rbyte !== 8'h5A) begin fails++; $display("FAIL rx_byte_kept: got %h expected 5a", rbyte); end
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL rx_poll_resumed: got %h (ok=%0d) expected 0000", w, ok); end
  endtask

  task automatic test_status_and_drop;
    logic [15:0] w;
    bit ok;
    int n99;
    resp = 16'h0000;
    wait_ncs_low(ok);
    checks++; if (!ok) begin fails++; $display("FAIL st_frame_start: got timeout expected ncs low"); end
    idle(2);
    sbyte = 8'h77;
    trig = 1'b1;
    idle(1);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL st_busy_set: got %b expected 1", busy); end
    trig = 1'b0;
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL st_poll1: got %h (ok=%0d) expected 0000", w, ok); end
    idle(3);
    sbyte = 8'h99;
    trig = 1'b1;
    idle(1);
    trig = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL st_busy_drop: got %b expected 1", busy); end
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL st_poll2: got %h (ok=%0d) expected 0000", w, ok); end
    wait_frame(w, ok);
    resp = 16'h4000;
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL st_poll3: got %h (ok=%0d) expected 0000", w, ok); end
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL st_poll_t1: got %h (ok=%0d) expected 0000", w, ok); end
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'h8077) begin fails++; $display("FAIL st_write: got %h (ok=%0d) expected 8077", w, ok); end
    n99 = 0;
    foreach (log_q[i]) if (log_q[i] == 16'h8099) n99++;
    checks++; if (n99 != 0) begin fails++; $display("FAIL drop_no_8099: got %0d frames expected 0", n99); end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] w;
    bit ok;
    int n;
    wait_frame(w, ok);
    resp = 16'hC0AB;
    wait_frame(w, ok);
    resp = 16'h4000;
    checks++; if (!ok || w !== 16'h0000) begin fails++; $display("FAIL rst_pre_read: got %h (ok=%0d) expected 0000", w, ok); end
    idle(12);
    checks++; if (received !== 1'b1 || rbyte !== 8'hAB) begin fails++; $display("FAIL rst_pre_rx: got %b/%h expected 1/ab", received, rbyte); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_pre_busy: got %b expected 0", busy); end
    sbyte = 8'h55;
    trig = 1'b1;
    idle(1);
    trig = 1'b0;
    wait_ncs_low(ok);
    n = 0;
    while (ok && nbits != 8 && n < 400) begin
      @(negedge MCLK_IN);
      n++;
    end
    checks++; if (!ok || nbits != 8) begin fails++; $display("FAIL rst_reach_bit7: got %0d bits expected 8", nbits); end
    RESET_IN = 1'b1;
    idle(1);
    checks++; if (ncs !== 1'b1 || sclk !== 1'b0) begin fails++; $display("FAIL rst_mid_spi: got ncs=%b sclk=%b expected 1/0", ncs, sclk); end
    checks++; if (received !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL rst_mid_flags: got rx=%b busy=%b expected 0/1", received, busy); end
    checks++; if (rbyte !== 8'h00) begin fails++; $display("FAIL rst_mid_rbyte: got %h expected 00", rbyte); end
    RESET_IN = 1'b0;
    idle(2);
    wait_frame(w, ok);
    checks++; if (!ok || w !== 16'hC00A) begin fails++; $display("FAIL rst_config: got %h (ok=%0d) expected c00a", w, ok); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_receive;
    test_status_and_drop;
    test_reset_mid_write;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
